// File: rtl/alu_pkg.sv
// Shared types for the arbitrated ALU: opcode encoding, FSM state and
// the saturation limit of the accepted-operation counter.
package alu_pkg;

   typedef enum logic [2:0] {
      OP_AND = 3'b000,
      OP_OR  = 3'b001,
      OP_ADD = 3'b010,
      OP_SUB = 3'b110,
      OP_SLT = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_EXEC = 2'b01,
      S_RESP = 2'b10
   } state_t;

   localparam logic [15:0] CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant selection: the search begins at ptr and wraps, so the
// first requester at or after ptr wins. Purely combinational.
module rr_arbiter
   import alu_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx,
   output logic          any
);

   logic          found;
   logic [IW-1:0] pos;

   // Walk requesters starting at ptr, keep the first one that is asserted.
   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      pos   = '0;
      for (int i = 0; i < N; i++) begin
         pos = IW'((int'(ptr) + i) % N);
         if (!found && req[pos]) begin
            found    = 1'b1;
            gnt[pos] = 1'b1;
            idx      = pos;
         end
      end
   end

   assign any = |req;

endmodule

// File: rtl/alu_arbiter.sv
// N requesters share one ALU. A round-robin arbiter picks one operation,
// the FSM captures its operands, evaluates for one cycle and presents a
// response that is held until the consumer takes it.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. Requesters hold req_valid and operands until their req_ready bit
// is seen; rsp_valid and all rsp_* fields stay constant until rsp_ready.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int W  = 32,
   parameter int N  = 4,
   localparam int IW = $clog2(N)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [N-1:0]        req_valid,
   output logic [N-1:0]        req_ready,
   input  logic [N-1:0][2:0]   req_f,
   input  logic [N-1:0][W-1:0] req_a,
   input  logic [N-1:0][W-1:0] req_b,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [W-1:0]        rsp_result,
   output logic                rsp_zero,
   output logic                rsp_err,
   output logic [IW-1:0]       rsp_id,
   output logic [15:0]         op_count,
   output logic [1:0]          dbg_state
);

   state_t        state_q, state_d;
   logic [IW-1:0] ptr_q;
   logic [2:0]    f_q;
   logic [W-1:0]  a_q, b_q;
   logic [IW-1:0] id_q;
   logic [W-1:0]  res_q;
   logic          zero_q, err_q;
   logic [IW-1:0] rid_q;
   logic [15:0]   cnt_q;

   logic [N-1:0]  gnt;
   logic [IW-1:0] gnt_idx;
   logic          gnt_any;
   logic          accept;
   logic [W-1:0]  alu_res;
   logic          alu_err;

   rr_arbiter #(.N(N), .IW(IW)) u_rr (
      .req (req_valid),
      .ptr (ptr_q),
      .gnt (gnt),
      .idx (gnt_idx),
      .any (gnt_any)
   );

   // Next state and accept decision; a new op may enter from IDLE or from
   // RESP in the same cycle the pending response is consumed.
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (gnt_any) begin
               accept  = 1'b1;
               state_d = S_EXEC;
            end
         end
         S_EXEC: state_d = S_RESP;
         S_RESP: begin
            if (rsp_ready) begin
               if (gnt_any) begin
                  accept  = 1'b1;
                  state_d = S_EXEC;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (rst) begin
         accept = 1'b0;
      end
   end

   assign req_ready = accept ? gnt : '0;

   // Single shared ALU working on the captured operands.
   always_comb begin
      alu_res = '0;
      alu_err = 1'b0;
      case (f_q)
         OP_AND:  alu_res = a_q & b_q;
         OP_OR:   alu_res = a_q | b_q;
         OP_ADD:  alu_res = a_q + b_q;
         OP_SUB:  alu_res = a_q - b_q;
         OP_SLT:  alu_res = {{(W-1){1'b0}}, (a_q < b_q)};
         default: alu_err = 1'b1;
      endcase
   end

   // State register, round-robin pointer and operand capture on accept.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         f_q     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         id_q    <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            ptr_q <= (gnt_idx == IW'(N-1)) ? '0 : gnt_idx + 1'b1;
            f_q   <= req_f[gnt_idx];
            a_q   <= req_a[gnt_idx];
            b_q   <= req_b[gnt_idx];
            id_q  <= gnt_idx;
         end
      end
   end

   // Response registers load only at the end of EXEC, so they stay put in RESP.
   always_ff @(posedge clk) begin
      if (rst) begin
         res_q  <= '0;
         zero_q <= 1'b1;
         err_q  <= 1'b0;
         rid_q  <= '0;
      end else if (state_q == S_EXEC) begin
         res_q  <= alu_res;
         zero_q <= (alu_res == '0);
         err_q  <= alu_err;
         rid_q  <= id_q;
      end
   end

   // Accepted-operation counter, sticks at its maximum.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (accept && (cnt_q != CNT_MAX)) begin
         cnt_q <= cnt_q + 16'd1;
      end
   end

   assign rsp_valid  = (state_q == S_RESP);
   assign rsp_result = res_q;
   assign rsp_zero   = zero_q;
   assign rsp_err    = err_q;
   assign rsp_id     = rid_q;
   assign op_count   = cnt_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: table of single-op vectors, then round-robin,
// backpressure, reset-in-flight and counter saturation sequences. Every
// accepted op pushes its expected response; a monitor pops on handshake.
module tb_alu_arbiter;
   import alu_pkg::*;

   localparam int W  = 32;
   localparam int N  = 4;
   localparam int IW = 2;

   logic                clk = 1'b0;
   logic                rst;
   logic [N-1:0]        req_valid;
   logic [N-1:0]        req_ready;
   logic [N-1:0][2:0]   req_f;
   logic [N-1:0][W-1:0] req_a;
   logic [N-1:0][W-1:0] req_b;
   logic                rsp_valid;
   logic                rsp_ready;
   logic [W-1:0]        rsp_result;
   logic                rsp_zero;
   logic                rsp_err;
   logic [IW-1:0]       rsp_id;
   logic [15:0]         op_count;
   logic [1:0]          dbg_state;

   int          checks = 0;
   int          errors = 0;
   logic [35:0] exp_q[$];
   logic [15:0] exp_cnt;

   typedef struct {
      logic [2:0]   f;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] res;
      logic         zero;
      logic         err;
   } vec_t;

   vec_t vecs[12];

   alu_arbiter #(.W(W), .N(N)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_f      (req_f),
      .req_a      (req_a),
      .req_b      (req_b),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_result (rsp_result),
      .rsp_zero   (rsp_zero),
      .rsp_err    (rsp_err),
      .rsp_id     (rsp_id),
      .op_count   (op_count),
      .dbg_state  (dbg_state)
   );

   // clock
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [N-1:0] onehot(input int id);
      logic [N-1:0] v;
      v     = '0;
      v[id] = 1'b1;
      return v;
   endfunction

   // Reference ALU written from the opcode table.
   function automatic logic [35:0] model(input logic [2:0] f, input logic [W-1:0] a,
                                         input logic [W-1:0] b, input int id);
      logic [W-1:0] r;
      logic         e;
      r = '0;
      e = 1'b0;
      case (f)
         3'b000:  r = a & b;
         3'b001:  r = a | b;
         3'b010:  r = a + b;
         3'b110:  r = a - b;
         3'b111:  r = (a < b) ? 32'd1 : 32'd0;
         default: e = 1'b1;
      endcase
      return {r, (r == '0), e, IW'(id)};
   endfunction

   function automatic void count_accept();
      if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
   endfunction

   // scoreboard monitor
   always @(negedge clk) begin
      logic [35:0] e;
      if (!rst && rsp_valid && rsp_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp actual %h expected none",
                     {rsp_result, rsp_zero, rsp_err, rsp_id});
         end else begin
            e = exp_q.pop_front();
            check("rsp", {rsp_result, rsp_zero, rsp_err, rsp_id}, e);
         end
      end
   end

   // One isolated operation from requester id, entered from IDLE.
   task automatic do_op(input int id, input logic [2:0] f, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] er,
                        input logic ez, input logic ee);
      tick();
      req_valid     = onehot(id);
      req_f[id]     = f;
      req_a[id]     = a;
      req_b[id]     = b;
      rsp_ready     = 1'b1;
      @(negedge clk);
      check("accept_ready", req_ready, onehot(id));
      exp_q.push_back({er, ez, ee, IW'(id)});
      count_accept();
      tick();
      req_valid = '0;
      @(negedge clk);
      check("exec_rsp_valid", rsp_valid, 1'b0);
      check("exec_ready", req_ready, '0);
      check("op_count", op_count, exp_cnt);
      tick();
      @(negedge clk);
      check("latency_rsp_valid", rsp_valid, 1'b1);
   endtask

   initial begin
      vecs[0]  = '{3'b010, 32'd5,        32'd7,        32'd12,       1'b0, 1'b0};
      vecs[1]  = '{3'b110, 32'd0,        32'd1,        32'hFFFFFFFF, 1'b0, 1'b0};
      vecs[2]  = '{3'b111, 32'd3,        32'hFFFFFFFF, 32'd1,        1'b0, 1'b0};
      vecs[3]  = '{3'b000, 32'h0F0,      32'hF00,      32'd0,        1'b1, 1'b0};
      vecs[4]  = '{3'b100, 32'h1234,     32'd1,        32'd0,        1'b1, 1'b1};
      vecs[5]  = '{3'b001, 32'h0F0,      32'hF00,      32'hFF0,      1'b0, 1'b0};
      vecs[6]  = '{3'b010, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 1'b0};
      vecs[7]  = '{3'b111, 32'hFFFFFFFF, 32'd3,        32'd0,        1'b1, 1'b0};
      vecs[8]  = '{3'b011, 32'd9,        32'd9,        32'd0,        1'b1, 1'b1};
      vecs[9]  = '{3'b101, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        1'b1, 1'b1};
      vecs[10] = '{3'b110, 32'd10,       32'd3,        32'd7,        1'b0, 1'b0};
      vecs[11] = '{3'b111, 32'd5,        32'd5,        32'd0,        1'b1, 1'b0};

      // reset, with requests pending to show req_ready stays low
      rst       = 1'b1;
      req_valid = '0;
      req_f     = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b0;
      exp_cnt   = '0;
      repeat (2) @(posedge clk);
      #1;
      req_valid = '1;
      @(negedge clk);
      check("rst_ready", req_ready, '0);
      check("rst_state", dbg_state, S_IDLE);
      check("rst_rsp", {rsp_valid, rsp_result, rsp_zero, rsp_err, rsp_id},
            {1'b0, 32'd0, 1'b1, 1'b0, 2'd0});
      check("rst_count", op_count, 16'd0);
      tick();
      rst       = 1'b0;
      req_valid = '0;

      // table-driven single operations
      for (int i = 0; i < 12; i++) begin
         do_op(i % N, vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].zero, vecs[i].err);
      end

      // round-robin from a fresh pointer, all requesters busy
      tick();
      rst = 1'b1;
      tick();
      rst     = 1'b0;
      exp_cnt = '0;
      for (int i = 0; i < N; i++) begin
         req_f[i] = 3'b010;
         req_a[i] = W'(100 * i + 1);
         req_b[i] = W'(3 * i);
      end
      req_valid = '1;
      rsp_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("rr_grant", req_ready, onehot(k % N));
         exp_q.push_back(model(3'b010, W'(100 * (k % N) + 1), W'(3 * (k % N)), k % N));
         count_accept();
         @(negedge clk);
         check("rr_exec_ready", req_ready, '0);
      end
      tick();
      req_valid = '0;
      @(negedge clk);
      check("rr_count", op_count, exp_cnt);

      // backpressure: pointer sits at 1, requester 2 alone, then 1 and 3 wait
      tick();
      req_valid = onehot(2);
      req_f[2]  = 3'b110;
      req_a[2]  = 32'd50;
      req_b[2]  = 32'd8;
      rsp_ready = 1'b0;
      @(negedge clk);
      check("bp_grant", req_ready, onehot(2));
      exp_q.push_back(model(3'b110, 32'd50, 32'd8, 2));
      count_accept();
      tick();
      req_valid = 4'b1010;
      @(negedge clk);
      check("bp_exec_ready", req_ready, '0);
      for (int k = 0; k < 5; k++) begin
         tick();
         @(negedge clk);
         check("bp_hold", {rsp_valid, rsp_result, rsp_zero, rsp_err, rsp_id, req_ready},
               {1'b1, 32'd42, 1'b0, 1'b0, 2'd2, 4'b0000});
      end
      tick();
      rsp_ready = 1'b1;
      @(negedge clk);
      check("bp_release_grant", req_ready, onehot(3));
      exp_q.push_back(model(3'b010, 32'd301, 32'd9, 3));
      count_accept();
      tick();
      req_valid = '0;
      tick();
      @(negedge clk);
      check("bp_count", op_count, exp_cnt);

      // reset while an op is executing: pointer moves to 2 first
      tick();
      req_valid = onehot(1);
      req_f[1]  = 3'b010;
      req_a[1]  = 32'd1;
      req_b[1]  = 32'd1;
      @(negedge clk);
      check("ro_grant", req_ready, onehot(1));
      tick();
      req_valid = '0;
      rst       = 1'b1;
      @(negedge clk);
      check("ro_exec_state", dbg_state, S_EXEC);
      tick();
      req_valid = '1;
      @(negedge clk);
      check("ro_state", dbg_state, S_IDLE);
      check("ro_ready", req_ready, '0);
      check("ro_rsp", {rsp_valid, rsp_result, rsp_zero, rsp_err, rsp_id},
            {1'b0, 32'd0, 1'b1, 1'b0, 2'd0});
      check("ro_count", op_count, 16'd0);
      exp_cnt = '0;
      tick();
      rst      = 1'b0;
      req_f[0] = 3'b010;
      req_a[0] = 32'd1;
      req_b[0] = 32'd0;
      @(negedge clk);
      check("ro_ptr_grant", req_ready, onehot(0));
      exp_q.push_back(model(3'b010, 32'd1, 32'd0, 0));
      count_accept();
      tick();
      req_valid = '0;
      tick();
      @(negedge clk);
      check("ro_after_count", op_count, exp_cnt);

      // saturation: preload the counter near its top, then keep accepting
      tick();
      dut.cnt_q = 16'hFFFD;
      exp_cnt   = 16'hFFFD;
      for (int k = 0; k < 4; k++) begin
         do_op(k, 3'b001, 32'h1 << k, 32'h100, (32'h1 << k) | 32'h100, 1'b0, 1'b0);
      end
      check("sat_count", op_count, 16'hFFFF);

      tick();
      @(negedge clk);
      check("drain", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
